// File: rtl/mmu_pkg.sv
// Shared MMU defaults and the signed-to-pixel saturation helper.
package mmu_pkg;

  localparam int unsigned ACC_WIDTH_DEF = 40;
  localparam int unsigned DEPTH_DEF     = 4;
  localparam int unsigned PIX_WIDTH_DEF = 8;

  // Saturate a sign-extended accumulator value into [0, 2^pw-1]; caller truncates to pw bits.
  function automatic logic signed [63:0] clamp_pix(input logic signed [63:0] v,
                                                  input int unsigned       pw);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< pw) - 64'sd1;
    if (v < 64'sd0)       return '0;
    else if (v > max_v)   return max_v;
    else                  return v;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Registered-output row FIFO: no fall-through, drops writes when full unless a read frees a slot.
module row_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             full, rd, wr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign valid_o   = (cnt_q != '0);
  assign rd        = rd_en_i && valid_o;
  assign wr        = wr_en_i && (!full || rd);
  assign drop_o    = wr_en_i && full && !rd;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr ? inc_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd ? inc_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr) mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mmu_output_deskew.sv
// Re-aligns skewed systolic-array column outputs, clamps them to pixels and buffers whole rows.
module mmu_output_deskew
  import mmu_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned PIX_WIDTH  = PIX_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [ACC_WIDTH*DEPTH-1:0]   acc_in,
  output logic [PIX_WIDTH*DEPTH-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic [15:0]                  row_count
);

  logic [DEPTH-1:0][PIX_WIDTH-1:0] clamped, aligned;
  logic [DEPTH-2:0]                vld_pipe_q;
  logic                            drop;
  logic                            overflow_q, overflow_d;
  logic [15:0]                     row_count_q, row_count_d;

  // Clamp on entry so the deskew chains only carry pixel-width data.
  for (genvar j = 0; j < DEPTH; j++) begin : g_col
    localparam int unsigned DLY = DEPTH - 1 - j;

    assign clamped[j] = PIX_WIDTH'(clamp_pix(64'($signed(acc_in[j*ACC_WIDTH +: ACC_WIDTH])),
                                             PIX_WIDTH));

    if (DLY == 0) begin : g_direct
      assign aligned[j] = clamped[j];
    end else begin : g_dly
      logic [DLY-1:0][PIX_WIDTH-1:0] sh_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sh_q <= '0;
        end else begin
          sh_q[0] <= clamped[j];
          for (int k = 1; k < DLY; k++) sh_q[k] <= sh_q[k-1];
        end
      end
      assign aligned[j] = sh_q[DLY-1];
    end
  end

  // Row tag travels alongside column 0 and marks the cycle the row is fully aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= in_valid;
      for (int k = 1; k < DEPTH - 1; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
    end
  end

  row_fifo #(
    .WIDTH      (PIX_WIDTH * DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (vld_pipe_q[DEPTH-2]),
    .wr_data_i (aligned),
    .rd_en_i   (out_ready),
    .rd_data_o (out_data),
    .valid_o   (out_valid),
    .drop_o    (drop)
  );

  always_comb begin
    overflow_d  = overflow_q | drop;
    row_count_d = row_count_q + 16'(out_valid && out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      row_count_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      row_count_q <= row_count_d;
    end
  end

  assign overflow  = overflow_q;
  assign row_count = row_count_q;

endmodule

// File: doc/mmu_output_deskew.md
MMU_OUTPUT_DESKEW -- requirements
Module: mmu_output_deskew

Interface
REQ-001 Parameter ACC_WIDTH, default 40: width of one accumulator column result.
REQ-002 Parameter DEPTH, default 4: number of systolic array columns.
REQ-003 Parameter PIX_WIDTH, default 8: width of one output pixel.
REQ-004 Parameter FIFO_DEPTH, default 4: number of aligned output rows buffered.
REQ-005 Port clk, input, 1: single clock; all logic SHALL be rising-edge triggered.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: asserted in the cycle that column 0 of a new result row is present on acc_in.
REQ-008 Port acc_in, input, ACC_WIDTH*DEPTH: bottom-row PE outputs; column j occupies bits [j*ACC_WIDTH +: ACC_WIDTH] and is signed two's complement.
REQ-009 Port out_data, output, PIX_WIDTH*DEPTH: one aligned, clamped pixel row; pixel j occupies bits [j*PIX_WIDTH +: PIX_WIDTH].
REQ-010 Port out_valid, output, 1: out_data holds a valid row.
REQ-011 Port out_ready, input, 1: consumer accepts the row when out_valid and out_ready are both high.
REQ-012 Port overflow, output, 1: sticky flag, set when an aligned row is lost because the FIFO is full.
REQ-013 Port row_count, output, 16: number of rows accepted by the consumer; wraps modulo 2^16.

Function
REQ-014 Skew model: the column j value of the row tagged by in_valid at cycle t SHALL be sampled from acc_in at cycle t+j.
REQ-015 Deskew: column j SHALL be delayed by DEPTH-1-j registers, so that all columns of the row are aligned at cycle t+DEPTH-1.
REQ-016 A valid-tag shift register of length DEPTH-1 SHALL track in_valid, so that back-to-back in_valid (one row per cycle) is supported.
REQ-017 Clamp per column: a negative value SHALL map to 0, a value greater than 2^PIX_WIDTH-1 SHALL map to 2^PIX_WIDTH-1, and any other value SHALL pass through its low PIX_WIDTH bits.
REQ-018 The aligned, clamped row SHALL be written into the FIFO at the rising edge that ends cycle t+DEPTH-1.
REQ-019 With the FIFO empty, out_valid SHALL rise in cycle t+DEPTH, giving a latency of DEPTH cycles.
REQ-020 The FIFO SHALL be first-in first-out; out_data SHALL hold the head entry and SHALL remain stable while out_valid is high and out_ready is low.
REQ-021 Full FIFO without a read in the same cycle: the incoming row SHALL be dropped, overflow SHALL be set, and stored entries SHALL be unchanged.
REQ-022 Full FIFO with a read in the same cycle: the write and the read SHALL both occur with no overflow.
REQ-023 Empty FIFO with a write in the same cycle: out_valid SHALL stay low that cycle, because there is no fall-through path.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL range from 0 to FIFO_DEPTH inclusive.
REQ-025 row_count SHALL increment by 1 on every out_valid && out_ready handshake.
REQ-026 The X-state of acc_in columns outside a tagged row's sample cycle SHALL NOT affect out_data.

Reset
REQ-027 While rst is high, the following SHALL clear: out_valid=0, out_data=0, overflow=0, row_count=0, FIFO pointers and occupancy=0, valid-tag shift register=0, deskew registers=0.
REQ-028 Reset asserted mid-row SHALL discard every partially deskewed row and every buffered row; the first in_valid after rst deasserts SHALL start a clean row.
REQ-029 overflow SHALL clear only on rst.

Structure
REQ-030 ACC_WIDTH, DEPTH and PIX_WIDTH defaults, and the signed-clamp function, SHALL reside in the shared package mmu_pkg.
REQ-031 The FIFO SHALL be a sub-module named row_fifo, parameterised by width and FIFO_DEPTH.
REQ-032 Deskew and clamp logic SHALL remain inside mmu_output_deskew.

Verification
REQ-033 Single row: in_valid at cycle 0; columns 10, 20, 30, 40 driven at cycles 0, 1, 2, 3 -> out_valid rises at cycle 4 with out_data = {40, 30, 20, 10}.
REQ-034 Clamp: column values -1, 0, 255, 300 -> output pixels 0, 0, 255, 255.
REQ-035 Streaming: in_valid for 8 consecutive cycles with out_ready=1 -> 8 rows in order with no gaps, row_count=8, overflow=0.
REQ-036 Backpressure: out_ready=0 while 6 rows arrive -> first 4 rows retained, overflow=1; after out_ready=1, rows 1-4 emerge in order.
REQ-037 Simultaneous read/write at full (4 entries, out_ready=1, new row arrives) -> occupancy stays 4, overflow stays 0.
REQ-038 Reset mid-row: rst pulsed at cycle 2 of a row -> no output row appears; the next row produces a correct output at latency 4.
